// File: rtl/hdc_pkg.sv
// Shared definitions for the hyperdimensional bundling datapath.
package hdc_pkg;
  localparam int unsigned HV_DIM        = 1024;
  localparam int unsigned FEATURE_COUNT = 617;
  localparam int unsigned LANES         = 16;
  localparam int unsigned CNT_W         = $clog2(FEATURE_COUNT + 1);
  localparam int unsigned BEATS         = HV_DIM / LANES;

  typedef logic [FEATURE_COUNT-1:0] col_t;
  typedef logic [CNT_W-1:0]         cnt_t;

  typedef enum logic [1:0] {IDLE, COLLECT, OUT} bundle_state_e;
endpackage

// File: rtl/hdc_popcount.sv
// Combinational popcount: byte-wide partial counts summed by a second adder stage.
module hdc_popcount #(
  parameter int unsigned WIDTH = 617,
  parameter int unsigned OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [OUT_W-1:0] count
);
  localparam int unsigned NCH   = (WIDTH + 7) / 8;
  localparam int unsigned PAD_W = NCH * 8;

  logic [PAD_W-1:0] padded;
  logic [3:0]       part [NCH];

  assign padded = PAD_W'(bits);

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      part[c] = '0;
      for (int b = 0; b < 8; b++) begin
        part[c] = part[c] + 4'(padded[c*8 + b]);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int c = 0; c < NCH; c++) begin
      count = count + OUT_W'(part[c]);
    end
  end
endmodule

// File: rtl/enc_bundle_seq.sv
// Sequential bundler: thresholds LANES column popcounts per beat and assembles
// the HV_DIM-bit hypervector plus its density, presented on a valid/ready output.
module enc_bundle_seq #(
  parameter int unsigned HV_DIM        = hdc_pkg::HV_DIM,
  parameter int unsigned FEATURE_COUNT = hdc_pkg::FEATURE_COUNT,
  parameter int unsigned LANES         = hdc_pkg::LANES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES*FEATURE_COUNT-1:0]     in_cols,
  input  logic [$clog2(FEATURE_COUNT+1)-1:0] threshold,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [HV_DIM-1:0]                  out_hv,
  output logic [$clog2(HV_DIM+1)-1:0]        out_density
);
  import hdc_pkg::bundle_state_e;
  import hdc_pkg::IDLE;
  import hdc_pkg::COLLECT;
  import hdc_pkg::OUT;

  localparam int unsigned CNT_W   = $clog2(FEATURE_COUNT + 1);
  localparam int unsigned BEATS   = HV_DIM / LANES;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DENS_W  = $clog2(HV_DIM + 1);
  localparam int unsigned LONES_W = $clog2(LANES + 1);

  if (HV_DIM % LANES != 0) begin : g_dim_check
    $error("enc_bundle_seq: HV_DIM must be a multiple of LANES");
  end

  bundle_state_e      state;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [HV_DIM-1:0]  hv_reg;
  logic [CNT_W-1:0]   thr_reg;
  logic [DENS_W-1:0]  density;

  logic [CNT_W-1:0]   lane_cnt [LANES];
  logic [LANES-1:0]   lane_bits;
  logic [LONES_W-1:0] beat_ones;
  logic [CNT_W-1:0]   thr_eff;
  logic               handshake;
  logic               last_beat;

  // The first beat has no latched threshold yet, so it uses the live input.
  assign thr_eff   = (state == IDLE) ? threshold : thr_reg;
  assign handshake = in_valid & in_ready;
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hdc_popcount #(.WIDTH(FEATURE_COUNT), .OUT_W(CNT_W)) u_pc (
      .bits  (in_cols[l*FEATURE_COUNT +: FEATURE_COUNT]),
      .count (lane_cnt[l])
    );
    assign lane_bits[l] = (lane_cnt[l] >= thr_eff);
  end

  hdc_popcount #(.WIDTH(LANES), .OUT_W(LONES_W)) u_beat_ones (
    .bits  (lane_bits),
    .count (beat_ones)
  );

  // beat_cnt is always zero in IDLE, so the same indexed write covers beat 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      hv_reg    <= '0;
      thr_reg   <= '0;
      density   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (handshake) begin
            for (int b = 0; b < BEATS; b++) begin
              if (beat_cnt == BEAT_W'(b)) hv_reg[b*LANES +: LANES] <= lane_bits;
            end
            if (state == IDLE) begin
              thr_reg <= threshold;
              density <= DENS_W'(beat_ones);
            end else begin
              density <= density + DENS_W'(beat_ones);
            end
            if (last_beat) begin
              state     <= OUT;
              beat_cnt  <= '0;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state    <= COLLECT;
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_hv      = hv_reg;
  assign out_density = density;
endmodule
